crossbar_2m2s: RTL and testbench
================================

Name: crossbar_2m2s

Overview:
- Two-master / two-slave request-acknowledge crossbar with a memory-backed target behind each slave port.
- Master side: each master request is routed by address MSB to slave 1 (MSB=0) or slave 2 (MSB=1).
- Slave side: each slave port arbitrates between the two masters (round-robin), performs the single-word read/write on its local memory, and returns ack/rdata to the granted master.
- Sits between bus masters and simple memory-mapped targets.

Parameters:
- DATA_WIDTH, 32, width of wdata/rdata.
- ADDR_WIDTH, 16, width of master address; bit ADDR_WIDTH-1 selects the slave.
- MEM_AW, 4, index bits per slave memory (2**MEM_AW words); memory index = addr[MEM_AW-1:0].

Ports:
- clock input 1: single clock, rising edge.
- reset input 1: synchronous, active-high.
- req_1m input 1: master 1 request.
- cmd_1m input 1: master 1 command, 0=read, 1=write.
- addr_1m input ADDR_WIDTH: master 1 address.
- wdata_1m input DATA_WIDTH: master 1 write data.
- ack_1m output 1: master 1 acknowledge.
- rdata_1m output DATA_WIDTH: master 1 read data.
- req_2m, cmd_2m, addr_2m, wdata_2m, ack_2m, rdata_2m: identical set for master 2.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - All ack and rdata outputs = 0.
  - All slave FSMs go to IDLE.
  - Round-robin pointers favour master 1.
  - Both memories cleared to 0.
- Master routing (combinational):
  - req to slave s = req_xm & (addr_xm[MSB] == s-1).
  - cmd/addr/wdata are forwarded unchanged.
  - ack_xm = OR of the two slave acks for master x.
  - rdata_xm = rdata from whichever slave is acking master x, else 0.
- Master protocol: master holds req, cmd, addr and wdata stable from assertion until it has seen ack and deasserted req. One outstanding request per master.
- Slave FSM states: IDLE, BUSY_M1, BUSY_M2.
  - IDLE:
    - At a rising edge with exactly one req seen: grant that master.
    - With both reqs seen: grant the master not served last; first grant after reset goes to master 1.
    - On grant: write performs mem[idx] <= wdata; read loads the rdata register with mem[idx]. The ack register is set and the FSM moves to BUSY_Mx.
    - Latency: ack and rdata are valid after exactly one edge from first sampling req.
  - BUSY_Mx:
    - ack_x stays high and rdata is held while req_x is high.
    - At the first edge with req_x low: ack_x and rdata cleared, last-served = x, back to IDLE.
    - Requests from the other master wait, with no ack, in the meantime.
  - Only one access per grant; no re-execution while req stays high.
  - Write grants return rdata = 0.
- Simultaneous and staggered requests to the same slave are serialized; no request is lost. A waiting request is granted in the IDLE cycle after the first completes.
- Requests from the two masters to different slaves proceed fully in parallel.
- Reset asserted mid-transaction aborts it: ack drops after the reset edge. A write already performed at grant is not undone, but memory is then cleared by reset.
- Address bits between MEM_AW and MSB-1 are ignored (aliasing).

Decomposition:
- Shared package:
  - CMD_READ=1'b0, CMD_WRITE=1'b1.
  - Slave FSM state encoding (IDLE, BUSY_M1, BUSY_M2).
  - Default widths.
- Sub-module xbar_slave_port: arbiter FSM + memory + per-master ack/rdata registers, instantiated twice.
- Master routing/muxing lives inline in crossbar_2m2s.

Test Plan:
1. Master 1 writes 0x12345678 to 0x0001, then reads 0x0001:
   - ack_1m is high one edge after req.
   - rdata_1m = 0x12345678.
   - Slave 2 stays idle.
2. Master 2 writes 0x0000A5BD to 0x0002, then reads 0x0002 -> rdata_2m = 0x0000A5BD.
3. Both masters write in the same cycle: M1 writes 0xEDB3 to 0x0003, M2 writes 0xCEA3 to 0x0004.
   - M1 is acked first; M2 is acked after M1 drops req.
   - Simultaneous reads then return 0xEDB3 to M1 and 0xCEA3 to M2, in round-robin order.
4. Staggered access:
   - M2 writes 0xEACD to 0x0005; M1 writes 0xE453 to 0x0006 10 ns later.
   - M2 is served first, then M1.
   - Reads then return 0xE453 (M1, from 0x0006) and 0xEACD (M2, from 0x0005).
5. Repeat scenarios 1–4 with addresses 0x8001–0x8006:
   - Only slave 2 is accessed.
   - Slave 1 memory is unchanged (a read of 0x0001 still returns 0x12345678).
6. Concurrency and reset:
   - M1 accesses 0x0001 while M2 accesses 0x8002 -> both acked in the same cycle.
   - Assert reset during BUSY -> acks drop and a subsequent read of 0x0001 returns 0.

Source files
------------

// File: rtl/crossbar_2m2s_pkg.sv
// Shared types and defaults for the 2-master / 2-slave crossbar.
// Command encoding and slave arbiter state encoding.
package crossbar_2m2s_pkg;

  localparam int DW_DEF  = 32;
  localparam int AW_DEF  = 16;
  localparam int MAW_DEF = 4;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_M1 = 2'd1,
    ST_BUSY_M2 = 2'd2
  } slv_state_e;

endpackage

// File: rtl/xbar_slave_port.sv
// One slave port: round-robin arbiter FSM, local memory,
// and the ack/rdata registers returned to the granted master.
module xbar_slave_port
  import crossbar_2m2s_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DEF,
  parameter int MEM_AW     = MAW_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req1_i,
  input  logic                  cmd1_i,
  input  logic [MEM_AW-1:0]     idx1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  input  logic                  req2_i,
  input  logic                  cmd2_i,
  input  logic [MEM_AW-1:0]     idx2_i,
  input  logic [DATA_WIDTH-1:0] wdata2_i,
  output logic                  ack1_o,
  output logic                  ack2_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << MEM_AW;

  slv_state_e            state_q;
  logic                  last_m2_q;
  logic                  ack1_q;
  logic                  ack2_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic gnt1_d;
  logic gnt2_d;

  // Grant master 1 unless master 2 also asks and master 1 went last.
  always_comb begin
    gnt1_d = req1_i & (~req2_i | last_m2_q);
    gnt2_d = req2_i & ~gnt1_d;
  end

  // Arbiter FSM: one access at grant, hold ack until req drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      last_m2_q <= 1'b1;
      ack1_q    <= 1'b0;
      ack2_q    <= 1'b0;
      rdata_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (1'b1)
            gnt1_d: begin
              if (cmd1_i == CMD_WRITE) begin
                mem_q[idx1_i] <= wdata1_i;
                rdata_q       <= '0;
              end else begin
                rdata_q <= mem_q[idx1_i];
              end
              ack1_q  <= 1'b1;
              state_q <= ST_BUSY_M1;
            end
            gnt2_d: begin
              if (cmd2_i == CMD_WRITE) begin
                mem_q[idx2_i] <= wdata2_i;
                rdata_q       <= '0;
              end else begin
                rdata_q <= mem_q[idx2_i];
              end
              ack2_q  <= 1'b1;
              state_q <= ST_BUSY_M2;
            end
            default: ;
          endcase
        end
        ST_BUSY_M1: begin
          if (!req1_i) begin
            ack1_q    <= 1'b0;
            rdata_q   <= '0;
            last_m2_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_BUSY_M2: begin
          if (!req2_i) begin
            ack2_q    <= 1'b0;
            rdata_q   <= '0;
            last_m2_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack1_o  = ack1_q;
  assign ack2_o  = ack2_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/crossbar_2m2s.sv
// Two-master / two-slave crossbar: address-MSB routing
// to two memory-backed slave ports, ack/rdata merged back.
module crossbar_2m2s
  import crossbar_2m2s_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DEF,
  parameter int ADDR_WIDTH = AW_DEF,
  parameter int MEM_AW     = MAW_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_1m,
  input  logic                  cmd_1m,
  input  logic [ADDR_WIDTH-1:0] addr_1m,
  input  logic [DATA_WIDTH-1:0] wdata_1m,
  output logic                  ack_1m,
  output logic [DATA_WIDTH-1:0] rdata_1m,
  input  logic                  req_2m,
  input  logic                  cmd_2m,
  input  logic [ADDR_WIDTH-1:0] addr_2m,
  input  logic [DATA_WIDTH-1:0] wdata_2m,
  output logic                  ack_2m,
  output logic [DATA_WIDTH-1:0] rdata_2m
);

  localparam int MSB = ADDR_WIDTH - 1;

  logic                  s1_req1, s1_req2;
  logic                  s2_req1, s2_req2;
  logic                  s1_ack1, s1_ack2;
  logic                  s2_ack1, s2_ack2;
  logic [DATA_WIDTH-1:0] s1_rdata, s2_rdata;

  // Middle address bits alias onto the same memory word.
  logic unused_addr;
  assign unused_addr = ^{addr_1m[MSB-1:MEM_AW],
                         addr_2m[MSB-1:MEM_AW]};

  // Route each master request by address MSB.
  always_comb begin
    s1_req1 = req_1m & ~addr_1m[MSB];
    s2_req1 = req_1m &  addr_1m[MSB];
    s1_req2 = req_2m & ~addr_2m[MSB];
    s2_req2 = req_2m &  addr_2m[MSB];
  end

  xbar_slave_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_AW    (MEM_AW)
  ) u_s1 (
    .clk_i   (clock),
    .rst_i   (reset),
    .req1_i  (s1_req1),
    .cmd1_i  (cmd_1m),
    .idx1_i  (addr_1m[MEM_AW-1:0]),
    .wdata1_i(wdata_1m),
    .req2_i  (s1_req2),
    .cmd2_i  (cmd_2m),
    .idx2_i  (addr_2m[MEM_AW-1:0]),
    .wdata2_i(wdata_2m),
    .ack1_o  (s1_ack1),
    .ack2_o  (s1_ack2),
    .rdata_o (s1_rdata)
  );

  xbar_slave_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_AW    (MEM_AW)
  ) u_s2 (
    .clk_i   (clock),
    .rst_i   (reset),
    .req1_i  (s2_req1),
    .cmd1_i  (cmd_1m),
    .idx1_i  (addr_1m[MEM_AW-1:0]),
    .wdata1_i(wdata_1m),
    .req2_i  (s2_req2),
    .cmd2_i  (cmd_2m),
    .idx2_i  (addr_2m[MEM_AW-1:0]),
    .wdata2_i(wdata_2m),
    .ack1_o  (s2_ack1),
    .ack2_o  (s2_ack2),
    .rdata_o (s2_rdata)
  );

  // Merge slave responses back onto each master.
  always_comb begin
    ack_1m   = s1_ack1 | s2_ack1;
    ack_2m   = s1_ack2 | s2_ack2;
    rdata_1m = '0;
    rdata_2m = '0;
    if (s1_ack1)      rdata_1m = s1_rdata;
    else if (s2_ack1) rdata_1m = s2_rdata;
    if (s1_ack2)      rdata_2m = s1_rdata;
    else if (s2_ack2) rdata_2m = s2_rdata;
  end

endmodule

// File: tb/tb_crossbar_2m2s.sv
// Scoreboard bench for crossbar_2m2s: directed accesses
// push expected rdata, a negedge monitor checks on ack rise.
module tb_crossbar_2m2s;
  import crossbar_2m2s_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_1m, cmd_1m, req_2m, cmd_2m;
  logic [15:0] addr_1m, addr_2m;
  logic [31:0] wdata_1m, wdata_2m;
  logic        ack_1m, ack_2m;
  logic [31:0] rdata_1m, rdata_2m;

  crossbar_2m2s dut (
    .clock   (clock),
    .reset   (reset),
    .req_1m  (req_1m),
    .cmd_1m  (cmd_1m),
    .addr_1m (addr_1m),
    .wdata_1m(wdata_1m),
    .ack_1m  (ack_1m),
    .rdata_1m(rdata_1m),
    .req_2m  (req_2m),
    .cmd_2m  (cmd_2m),
    .addr_2m (addr_2m),
    .wdata_2m(wdata_2m),
    .ack_2m  (ack_2m),
    .rdata_2m(rdata_2m)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t1 = 0;
  int t2 = 0;
  logic a1_prev = 1'b0;
  logic a2_prev = 1'b0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: on each ack rise compare rdata to the queue head.
  always @(negedge clock) begin
    if (ack_1m && !a1_prev) begin
      t1 = cyc;
      if (q1.size() == 0) check("m1_unexpected_ack", 32'd1, 32'd0);
      else check("m1_rdata", rdata_1m, q1.pop_front());
    end
    if (ack_2m && !a2_prev) begin
      t2 = cyc;
      if (q2.size() == 0) check("m2_unexpected_ack", 32'd1, 32'd0);
      else check("m2_rdata", rdata_2m, q2.pop_front());
    end
    a1_prev = ack_1m;
    a2_prev = ack_2m;
  end

  task automatic access(input int m, input logic c,
                        input logic [15:0] a,
                        input logic [31:0] d,
                        input logic [31:0] e,
                        input bit chk_lat,
                        input string tag);
    int lat;
    bit got;
    logic ak;
    @(negedge clock);
    if (m == 1) begin
      q1.push_back(e);
      cmd_1m = c; addr_1m = a; wdata_1m = d; req_1m = 1'b1;
    end else begin
      q2.push_back(e);
      cmd_2m = c; addr_2m = a; wdata_2m = d; req_2m = 1'b1;
    end
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clock);
      ak = (m == 1) ? ack_1m : ack_2m;
      if (ak) begin
        got = 1'b1;
        lat = i;
      end
    end
    if (m == 1) req_1m = 1'b0;
    else req_2m = 1'b0;
    if (!got) begin
      check({tag, "_ack_timeout"}, 32'd0, 32'd1);
    end else begin
      if (chk_lat) check({tag, "_latency"}, lat, 32'd1);
      @(negedge clock);
      ak = (m == 1) ? ack_1m : ack_2m;
      check({tag, "_ack_drop"}, {31'd0, ak}, 32'd0);
    end
  endtask

  task automatic idle_watch(input logic hi, input string tag);
    logic [1:0] st;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      st = hi ? dut.u_s1.state_q : dut.u_s2.state_q;
      check({tag, "_other_idle"}, {30'd0, st}, {30'd0, ST_IDLE});
    end
  endtask

  task automatic scenario(input logic [15:0] b);
    // single master 1 write/read
    fork
      access(1, CMD_WRITE, b | 16'h1, 32'h12345678, 32'h0, 1, "s1w");
      idle_watch(b[15], "s1w");
    join
    access(1, CMD_READ, b | 16'h1, 32'h0, 32'h12345678, 1, "s1r");
    // single master 2 write/read
    access(2, CMD_WRITE, b | 16'h2, 32'h0000A5BD, 32'h0, 1, "s2w");
    access(2, CMD_READ, b | 16'h2, 32'h0, 32'h0000A5BD, 1, "s2r");
    // simultaneous writes, then simultaneous reads
    fork
      access(1, CMD_WRITE, b | 16'h3, 32'hEDB3, 32'h0, 0, "s3w1");
      access(2, CMD_WRITE, b | 16'h4, 32'hCEA3, 32'h0, 0, "s3w2");
    join
    check("s3w_m1_first", {31'd0, t1 < t2}, 32'd1);
    fork
      access(1, CMD_READ, b | 16'h3, 32'h0, 32'hEDB3, 0, "s3r1");
      access(2, CMD_READ, b | 16'h4, 32'h0, 32'hCEA3, 0, "s3r2");
    join
    check("s3r_m1_first", {31'd0, t1 < t2}, 32'd1);
    // staggered: master 2 one cycle ahead
    fork
      access(2, CMD_WRITE, b | 16'h5, 32'hEACD, 32'h0, 1, "s4w2");
      begin
        @(negedge clock);
        access(1, CMD_WRITE, b | 16'h6, 32'hE453, 32'h0, 0, "s4w1");
      end
    join
    check("s4w_m2_first", {31'd0, t2 < t1}, 32'd1);
    fork
      access(1, CMD_READ, b | 16'h6, 32'h0, 32'hE453, 0, "s4r1");
      access(2, CMD_READ, b | 16'h5, 32'h0, 32'hEACD, 0, "s4r2");
    join
    check("s4r_m2_first", {31'd0, t2 < t1}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_1m = 1'b0; cmd_1m = 1'b0; addr_1m = '0; wdata_1m = '0;
    req_2m = 1'b0; cmd_2m = 1'b0; addr_2m = '0; wdata_2m = '0;
    repeat (3) @(negedge clock);
    check("rst_ack_1m", {31'd0, ack_1m}, 32'd0);
    check("rst_ack_2m", {31'd0, ack_2m}, 32'd0);
    check("rst_rdata_1m", rdata_1m, 32'd0);
    check("rst_rdata_2m", rdata_2m, 32'd0);
    check("rst_s1_idle", {30'd0, dut.u_s1.state_q}, {30'd0, ST_IDLE});
    check("rst_s2_idle", {30'd0, dut.u_s2.state_q}, {30'd0, ST_IDLE});
    reset = 1'b0;

    scenario(16'h0000);
    scenario(16'h8000);
    access(1, CMD_READ, 16'h0001, 32'h0, 32'h12345678, 1, "s5_s1kept");
    access(2, CMD_READ, 16'h0003, 32'h0, 32'hEDB3, 1, "s5_s1kept3");

    // different slaves in parallel
    fork
      access(1, CMD_READ, 16'h0001, 32'h0, 32'h12345678, 1, "c1");
      access(2, CMD_READ, 16'h8002, 32'h0, 32'h0000A5BD, 1, "c2");
    join
    check("par_same_cycle", t1, t2);

    // aliasing of the middle address bits
    access(1, CMD_READ, 16'h0FF1, 32'h0, 32'h12345678, 1, "alias");

    // reset while busy
    @(negedge clock);
    q1.push_back(32'hEDB3);
    cmd_1m = CMD_READ; addr_1m = 16'h0003; req_1m = 1'b1;
    @(negedge clock);
    check("busy_ack", {31'd0, ack_1m}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rst_busy_ack", {31'd0, ack_1m}, 32'd0);
    check("rst_busy_rdata", rdata_1m, 32'd0);
    reset = 1'b0;
    req_1m = 1'b0;
    @(negedge clock);
    access(1, CMD_READ, 16'h0001, 32'h0, 32'h0, 1, "post_rst1");
    access(2, CMD_READ, 16'h8002, 32'h0, 32'h0, 1, "post_rst2");

    repeat (2) @(negedge clock);
    check("q1_drained", q1.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
